data_ram_resp: RTL and testbench

Single-port data memory responder answering load/store requests from the MEM pipeline stage. It accepts one request at a time over a req/ack handshake, waits a fixed LATENCY, performs a byte-enabled write or a word read, and returns a one-cycle ack, with an error flag for misaligned or out-of-range addresses. It sits beside the MEM stage and serves as the memory-side end of that stage's load/store interface.

---
 rtl/data_ram_resp.sv | 97 +++++++++
 tb/tb_data_ram_resp.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_resp.sv
// Single-port data memory responder for the MEM stage: one request at a time,
// fixed latency, byte-enabled stores, word loads, error on bad addresses.
module data_ram_resp #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [3:0]        sel_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] idx_c;
  logic              err_c;
  logic              access_c;
  logic              mem_we_c;

  // Address decode and error check work on the captured request only.
  assign idx_c    = addr_q[ADDR_W+1:2];
  assign err_c    = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'd0);
  assign access_c = (state == WAIT) && (cnt == '0);
  assign mem_we_c = access_c && we_q && !err_c && !rst;
  assign busy_o   = (state != IDLE);

  // Memory array is never reset; a reset during WAIT suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) mem[idx_c][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            sel_q   <= sel_i;
            wdata_q <= wdata_i;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            ack_o   <= 1'b1;
            err_o   <= err_c;
            rdata_o <= (err_c || we_q) ? 32'd0 : mem[idx_c];
            state   <= RESP;
          end
        end
        RESP: begin
          ack_o <= 1'b0;
          err_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp: scoreboard of expected ack payloads
// plus per-scenario timing checks, on LATENCY=2 and LATENCY=1 instances.
module tb_data_ram_resp;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req1;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ack, err, busy;
  logic [31:0] rdata;
  logic        ack1, err1, busy1;
  logic [31:0] rdata1;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  exp_t q[$];
  exp_t q1[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_ram_resp #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .sel_i(sel),
    .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .err_o(err), .busy_o(busy)
  );

  data_ram_resp #(.ADDR_W(10), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .req_i(req1), .we_i(we), .addr_i(addr), .sel_i(sel),
    .wdata_i(wdata), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1), .busy_o(busy1)
  );

  // Scoreboard for the LATENCY=2 instance: every ack pops one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (ack) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ack: ack=1 at cycle %0d, required no ack", cyc);
        end else begin
          e = q.pop_front();
          if (rdata !== e.rdata || err !== e.err) begin
            fails++;
            $display("FAIL scoreboard: rdata=%h err=%b, required rdata=%h err=%b",
                     rdata, err, e.rdata, e.err);
          end
        end
      end else if (err) begin
        checks++;
        fails++;
        $display("FAIL err_without_ack: err=1 ack=0 at cycle %0d", cyc);
      end
    end
  end

  // Present a request for one edge, then scramble the fields while WAIT runs.
  task automatic start(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output int e0);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; sel = s; wdata = d;
    @(negedge clk);
    e0 = cyc;
    req = 1'b0; we = ~w; addr = 32'hFFFF_FFFF; sel = ~s; wdata = ~d;
  endtask

  task automatic wait_ack(output int at);
    bit got = 0;
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1;
        at  = cyc;
        break;
      end
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL ack_timeout: no ack within 20 cycles, required ack");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({ack, err, busy} !== 3'b000 || rdata !== 32'd0) begin
        fails++;
        $display("FAIL reset_idle: ack=%b err=%b busy=%b rdata=%h, required 0 0 0 00000000",
                 ack, err, busy, rdata);
      end
    end
  endtask

  task automatic test_store_load();
    int e0, at;
    q.push_back('{32'd0, 1'b0});
    start(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, e0);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_accept: busy=%b, required 1", busy);
    end
    wait_ack(at);
    checks++;
    if (at != e0 + 2) begin
      fails++;
      $display("FAIL ack_timing: ack at cycle %0d, required %0d", at, e0 + 2);
    end
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ack_one_cycle: ack=%b busy=%b, required 0 0", ack, busy);
    end
    q.push_back('{32'hDEAD_BEEF, 1'b0});
    start(1'b0, 32'h10, 4'h0, 32'h0, e0);
    wait_ack(at);
  endtask

  task automatic test_partial_store();
    int e0, at;
    q.push_back('{32'd0, 1'b0});
    start(1'b1, 32'h10, 4'b0101, 32'h1122_3344, e0);
    wait_ack(at);
    q.push_back('{32'hDE22_BE44, 1'b0});
    start(1'b0, 32'h10, 4'h0, 32'h0, e0);
    wait_ack(at);
    repeat (2) @(negedge clk);
    checks++;
    if (rdata !== 32'hDE22_BE44) begin
      fails++;
      $display("FAIL rdata_hold: rdata=%h, required de22be44", rdata);
    end
  endtask

  task automatic test_errors();
    int e0, at;
    q.push_back('{32'd0, 1'b0});
    start(1'b1, 32'h0, 4'hF, 32'h0BAD_F00D, e0);
    wait_ack(at);
    q.push_back('{32'd0, 1'b1});
    start(1'b0, 32'h12, 4'h0, 32'h0, e0);
    wait_ack(at);
    q.push_back('{32'd0, 1'b1});
    start(1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, e0);
    wait_ack(at);
    q.push_back('{32'h0BAD_F00D, 1'b0});
    start(1'b0, 32'h0, 4'h0, 32'h0, e0);
    wait_ack(at);
  endtask

  task automatic test_reset_abort();
    int e0, at;
    bit seen = 0;
    start(1'b1, 32'h10, 4'hF, 32'h5555_5555, e0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0) begin
      fails++;
      $display("FAIL abort_busy: busy=%b ack=%b, required 0 0", busy, ack);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) seen = 1;
    end
    checks++;
    if (seen) begin
      fails++;
      $display("FAIL abort_no_ack: ack seen=1, required 0");
    end
    q.push_back('{32'hDE22_BE44, 1'b0});
    start(1'b0, 32'h10, 4'h0, 32'h0, e0);
    wait_ack(at);
  endtask

  // LATENCY=1 with req held: acks every third cycle; mid-WAIT field edits ignored.
  task automatic test_back_to_back();
    logic exp_ack;
    q1.push_back('{32'd0, 1'b0});
    q1.push_back('{32'hA5A5_A5A5, 1'b0});
    q1.push_back('{32'd0, 1'b0});
    q1.push_back('{32'd0, 1'b0});
    @(negedge clk);
    req1 = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'hF; wdata = 32'hA5A5_A5A5;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      exp_ack = (k % 3 == 1) && (k <= 10);
      checks++;
      if (ack1 !== exp_ack) begin
        fails++;
        $display("FAIL b2b_ack k=%0d: ack=%b, required %b", k, ack1, exp_ack);
      end
      if (ack1 && q1.size() != 0) begin
        e = q1.pop_front();
        checks++;
        if (rdata1 !== e.rdata || err1 !== e.err) begin
          fails++;
          $display("FAIL b2b_data k=%0d: rdata=%h err=%b, required rdata=%h err=%b",
                   k, rdata1, err1, e.rdata, e.err);
        end
      end
      case (k)
        0, 6:  begin we = 1'b0; sel = 4'h0; wdata = 32'h0; end
        3:     begin we = 1'b1; sel = 4'hF; wdata = 32'h0; end
        10:    req1 = 1'b0;
        default: ;
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req1 = 1'b0; we = 1'b0;
    addr = 32'd0; sel = 4'd0; wdata = 32'd0;
    test_reset();
    test_store_load();
    test_partial_store();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: pending=%0d/%0d, required 0/0", q.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
